// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch (IF) and data (MEM) stages: MEM first, IF wins after a MEM streak.
// Grant to bus_req takes 1 cycle; ack is 1 cycle after bus_ready, then one DONE cycle; requesters stall until ack.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DAT_WIDTH      = 32,
  parameter int MAX_MEM_STREAK = 4,
  parameter int TIMEOUT        = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DAT_WIDTH-1:0]  if_rdata,
  output logic                  if_ack,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DAT_WIDTH-1:0]  mem_wdata,
  output logic [DAT_WIDTH-1:0]  mem_rdata,
  output logic                  mem_ack,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DAT_WIDTH-1:0]  bus_wdata,
  input  logic [DAT_WIDTH-1:0]  bus_rdata,
  input  logic                  bus_ready,
  output logic                  bus_err,
  output logic                  stall_if,
  output logic                  stall_mem
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    IF_WAIT,
    MEM_WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [SW-1:0] streak;
  logic          mem_pend;
  logic          if_turn;

  assign mem_pend  = mem_rd | mem_wr;
  // IF takes the next grant once MEM has won MAX_MEM_STREAK times in a row while IF waited.
  assign if_turn   = if_req && (streak == STREAK_MAX);
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_pend & ~mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      streak    <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (mem_pend && !if_turn) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_wr;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            streak    <= if_req ? streak + 1'b1 : '0;
            state     <= MEM_WAIT;
          end else if (if_req) begin
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= if_addr;
            streak   <= '0;
            state    <= IF_WAIT;
          end
        end
        IF_WAIT, MEM_WAIT: begin
          if (bus_ready) begin
            bus_req <= 1'b0;
            timer   <= '0;
            state   <= DONE;
            if (state == IF_WAIT) begin
              if_ack   <= 1'b1;
              if_rdata <= bus_rdata;
            end else begin
              mem_ack <= 1'b1;
              if (!bus_we) mem_rdata <= bus_rdata;
            end
          end else if (timer == TIMER_LAST) begin
            // Abort with a zero-data ack so the stalled stage can make progress.
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            timer   <= '0;
            state   <= DONE;
            if (state == IF_WAIT) begin
              if_ack   <= 1'b1;
              if_rdata <= '0;
            end else begin
              mem_ack <= 1'b1;
              if (!bus_we) mem_rdata <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  a_one_ack: assert property (@(posedge clk) disable iff (rst) !(if_ack && mem_ack));

  a_bus_hold: assert property (@(posedge clk) disable iff (rst)
    (bus_req && !bus_ready && timer != TIMER_LAST) |=>
      (bus_req && $stable(bus_addr) && $stable(bus_we) && $stable(bus_wdata)));

endmodule
